// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared types and helpers for the serial scan link
//             (scan_shift_tx transmitter, scan_shift_rx receiver).
//  Contents : scan_tx_state_e  - transmitter state encoding
//             frame_bits()     - serial bits per frame incl. optional parity
//             SCAN_GAP_PERIODS - idle bit periods inserted between frames
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } scan_tx_state_e;

    // Bit periods of ser_frame low between frames, so the receiver can
    // always resynchronise on the frame boundary.
    localparam int SCAN_GAP_PERIODS = 1;

    function automatic int frame_bits(input int width, input bit parity_en);
        return width + (parity_en ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_bit_timer
//  Purpose  : Bit-period timer for the serial scan link. Counts DIV clock
//             cycles per bit while 'run' is high and pulses tick_o in the
//             last cycle of each period. Held at zero while 'run' is low.
//  Ports    : clk    in  system clock, rising edge
//             rst    in  asynchronous active-high reset
//             run    in  enable; counter clears when low
//             tick_o out one-cycle pulse at div_cnt == DIV-1
//  Revision : 1.0  initial release
// ============================================================================
module scan_bit_timer #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick_o
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("scan_bit_timer: DIV must be >= 1");
        end
    endgenerate

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    assign tick_o = run && (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!run || tick_o) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module   : scan_shift_tx
//  Purpose  : Parallel-to-serial scan unloader. Accepts a WIDTH-bit word on a
//             valid/ready handshake and shifts it out one bit per DIV cycles,
//             followed by a gap of ser_frame low before the next frame.
//  Macro    : SCAN_TX_PARITY_EN - when defined, an even-parity bit (XOR of the
//             data bits) is appended to each frame.
//  Ports    : clk        in  system clock, rising edge
//             rst        in  asynchronous active-high reset
//             in_data    in  word to transmit (WIDTH bits)
//             in_valid   in  in_data valid
//             in_ready   out block can accept a word (IDLE)
//             ser_out    out serial data bit
//             ser_frame  out high during a frame's bit periods
//             ser_strobe out last cycle of each bit period (sample point)
//             busy       out high in SHIFT or GAP
//             done       out one-cycle pulse in the final cycle of a frame
//  Revision : 1.0  initial release
// ============================================================================
module scan_shift_tx
    import scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_strobe,
    output logic             busy,
    output logic             done
);

`ifdef SCAN_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FRAME_BITS = frame_bits(WIDTH, PARITY_EN);
    localparam int BW         = $clog2(WIDTH + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] LAST_GAP = BW'(SCAN_GAP_PERIODS - 1);

    generate
        if (WIDTH < 1) begin : g_width_check
            $error("scan_shift_tx: WIDTH must be >= 1");
        end
        if (DIV < 1) begin : g_div_check
            $error("scan_shift_tx: DIV must be >= 1");
        end
    endgenerate

    scan_tx_state_e   state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    // Counts data bits in SHIFT and gap periods in GAP.
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tick;
    logic             timer_run;
    logic             data_bit;
    logic             cur_bit;

    assign timer_run = (state_q != IDLE);

    scan_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .tick_o (tick)
    );

    // The outgoing bit always sits at the shift-out end of sr.
    assign data_bit = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

`ifdef SCAN_TX_PARITY_EN
    logic parity_q, parity_d;
    // Once all data bits have gone, bit_cnt points at the parity slot.
    assign cur_bit = (bit_cnt_q == BW'(WIDTH)) ? parity_q : data_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    always_comb begin
        parity_d = parity_q;
        if (state_q == IDLE && in_valid) begin
            parity_d = ^in_data;
        end
    end
`else
    assign cur_bit = data_bit;
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        in_ready   = 1'b0;
        ser_out    = 1'b0;
        ser_frame  = 1'b0;
        ser_strobe = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_d      = in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                busy       = 1'b1;
                ser_frame  = 1'b1;
                ser_out    = cur_bit;
                ser_strobe = tick;
                if (tick) begin
                    sr_d = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    if (bit_cnt_q == LAST_BIT) begin
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            GAP: begin
                busy = 1'b1;
                if (tick) begin
                    if (bit_cnt_q == LAST_GAP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_shift_tx
//  Purpose  : Self-checking bench for scan_shift_tx. Three instances:
//             u_a WIDTH=8 DIV=1 MSB first, u_b DIV=3 MSB first,
//             u_c DIV=2 LSB first. Expected outputs come from a timeline
//             model of the serial frame computed per cycle after acceptance.
//  Macro    : SCAN_TX_PARITY_EN - enables parity expectations and test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_shift_tx;

`ifdef SCAN_TX_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       rdy   [3];
    logic       so    [3];
    logic       fr    [3];
    logic       st    [3];
    logic       bz    [3];
    logic       dn    [3];

    int n_checks = 0;
    int n_pass   = 0;

    scan_shift_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .in_data(data[0]), .in_valid(valid[0]),
        .in_ready(rdy[0]), .ser_out(so[0]), .ser_frame(fr[0]),
        .ser_strobe(st[0]), .busy(bz[0]), .done(dn[0]));

    scan_shift_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .in_data(data[1]), .in_valid(valid[1]),
        .in_ready(rdy[1]), .ser_out(so[1]), .ser_frame(fr[1]),
        .ser_strobe(st[1]), .busy(bz[1]), .done(dn[1]));

    scan_shift_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .in_data(data[2]), .in_valid(valid[2]),
        .in_ready(rdy[2]), .ser_out(so[2]), .ser_frame(fr[2]),
        .ser_strobe(st[2]), .busy(bz[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int div_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit msb_of(input int k);
        return (k != 2);
    endfunction

    // Cycles from the accept edge to the first IDLE cycle after the frame.
    function automatic int frame_len(input int k);
        return FB * div_of(k) + div_of(k) + 1;
    endfunction

    // Observed vector: {ser_out, ser_frame, ser_strobe, busy, done, in_ready}
    function automatic logic [5:0] obs(input int k);
        return {so[k], fr[k], st[k], bz[k], dn[k], rdy[k]};
    endfunction

    // Reference model: t = cycles after the accept edge (t=0 is the first
    // bit cycle). Frame bit i occupies cycles i*div .. i*div+div-1.
    function automatic logic [5:0] exp_vec(input int div, input bit msb,
                                           input logic [7:0] w, input int t);
        int   i;
        logic b;
        logic s;
        if (t < FB * div) begin
            i = t / div;
            if (i < 8) b = msb ? w[7 - i] : w[i];
            else       b = ^w;
            s = ((t % div) == (div - 1));
            return {b, 1'b1, s, 1'b1, s && (i == FB - 1), 1'b0};
        end else if (t < FB * div + div) begin
            return 6'b000100;
        end
        return 6'b000001;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== 6'b000001)
                $display("FAIL reset k=%0d got=%b exp=%b", k, obs(k), 6'b000001);
            else n_pass++;
        end
        #2 rst = 1'b0;
    endtask

    // Sends one word on instance k and checks every cycle through the gap
    // and the following IDLE cycle.
    task automatic test_frame(input string name, input int k, input logic [7:0] w);
        int nd;
        nd = 0;
        @(posedge clk); #1;
        valid[k] = 1'b1;
        data[k]  = w;
        @(negedge clk);
        n_checks++;
        if (rdy[k] !== 1'b1) $display("FAIL %s_ready k=%0d got=%b exp=1", name, k, rdy[k]);
        else n_pass++;
        @(posedge clk); #1;
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
        for (int t = 0; t < frame_len(k); t++) begin
            @(negedge clk);
            if (dn[k] === 1'b1) nd++;
            n_checks++;
            if (obs(k) !== exp_vec(div_of(k), msb_of(k), w, t))
                $display("FAIL %s k=%0d w=%h t=%0d got=%b exp=%b", name, k, w, t,
                         obs(k), exp_vec(div_of(k), msb_of(k), w, t));
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (nd != 1) $display("FAIL %s_done_count k=%0d got=%0d exp=1", name, k, nd);
        else n_pass++;
    endtask

    task automatic test_directed;
        test_frame("a5_div1", 0, 8'hA5);
        test_frame("3c_div3", 1, 8'h3C);
        test_frame("01_lsb", 2, 8'h01);
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            test_frame("random", int'($urandom_range(0, 2)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int l1;
        int done_at;
        int first_at;
        int low_cnt;
        l1       = frame_len(0);
        done_at  = -1;
        first_at = -1;
        low_cnt  = 0;
        @(posedge clk); #1;
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        @(posedge clk); #1;
        data[0]  = 8'h00;
        for (int t = 0; t < 2 * l1; t++) begin
            @(negedge clk);
            n_checks++;
            if (t < l1) begin
                if (obs(0) !== exp_vec(1, 1'b1, 8'hFF, t))
                    $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs(0),
                             exp_vec(1, 1'b1, 8'hFF, t));
                else n_pass++;
            end else begin
                if (obs(0) !== exp_vec(1, 1'b1, 8'h00, t - l1))
                    $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs(0),
                             exp_vec(1, 1'b1, 8'h00, t - l1));
                else n_pass++;
            end
            if (dn[0] === 1'b1 && done_at < 0) done_at = t;
            if (done_at >= 0 && t > done_at && first_at < 0) begin
                if (fr[0] === 1'b1) first_at = t;
                else low_cnt++;
            end
            @(posedge clk); #1;
            if (t + 1 == l1) valid[0] = 1'b0;
        end
        n_checks++;
        if (first_at < 0 || low_cnt != 2)
            $display("FAIL b2b_spacing got=%0d exp=2 (first_at=%0d)", low_cnt, first_at);
        else n_pass++;
    endtask

    task automatic test_valid_drop;
        @(posedge clk); #1;
        valid[1] = 1'b1;
        data[1]  = 8'hC3;
        #3 valid[1] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            n_checks++;
            if (obs(1) !== 6'b000001)
                $display("FAIL valid_drop t=%0d got=%b exp=%b", t, obs(1), 6'b000001);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        int nd;
        w  = 8'hD6;
        nd = 0;
        @(posedge clk); #1;
        valid[0] = 1'b1;
        data[0]  = w;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== exp_vec(1, 1'b1, w, t))
                $display("FAIL rstmid_pre t=%0d got=%b exp=%b", t, obs(0),
                         exp_vec(1, 1'b1, w, t));
            else n_pass++;
            if (t < 3) begin
                @(posedge clk); #1;
            end
        end
        // Mid-cycle, well away from either clock edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs(0) !== 6'b000001)
            $display("FAIL rstmid_async got=%b exp=%b", obs(0), 6'b000001);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) nd++;
            n_checks++;
            if (obs(0) !== 6'b000001)
                $display("FAIL rstmid_after t=%0d got=%b exp=%b", t, obs(0), 6'b000001);
            else n_pass++;
        end
        n_checks++;
        if (nd != 0) $display("FAIL rstmid_no_done got=%0d exp=0", nd);
        else n_pass++;
        test_frame("after_rst", 0, 8'h5B);
    endtask

`ifdef SCAN_TX_PARITY_EN
    task automatic test_parity;
        test_frame("parity_07", 0, 8'h07);
        test_frame("parity_03", 0, 8'h03);
        test_frame("parity_div3", 1, 8'h07);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid();
`ifdef SCAN_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
